// File: rtl/l2_dram_port.sv
`default_nettype none
// ============================================================================
// Module   : l2_dram_port
// Purpose  : L2-side initiator for whole-block refills and writebacks, split
//            into SUBBLOCKS beats on the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module l2_dram_port #(
  parameter int ADDR_BITS  = 32,
  parameter int BLOCK_BITS = 512,
  parameter int SUBBLOCKS  = 4,
  parameter int STRB_BITS  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_we,
  input  logic [ADDR_BITS-1:0]            req_addr,
  input  logic [BLOCK_BITS-1:0]           req_wdata,
  output logic                            resp_valid,
  output logic                            resp_we,
  output logic [BLOCK_BITS-1:0]           resp_rdata,
  output logic [ADDR_BITS-1:0]            mem_addr,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [STRB_BITS-1:0]            mem_wstrb,
  output logic [BLOCK_BITS/SUBBLOCKS-1:0] mem_wdata,
  input  logic [STRB_BITS-1:0]            mem_rstrb,
  input  logic [BLOCK_BITS/SUBBLOCKS-1:0] mem_rdata,
  input  logic                            mem_dready,
  input  logic                            mem_accR,
  input  logic                            mem_accW
);

  localparam int c_BEAT_BITS = BLOCK_BITS / SUBBLOCKS;
  localparam int c_OFF_BITS  = $clog2(BLOCK_BITS / 8);
  localparam logic [ADDR_BITS-1:0] c_ALIGN_MASK =
    ~(ADDR_BITS'((1 << c_OFF_BITS) - 1));
  localparam logic [STRB_BITS-1:0] c_LAST_BEAT = STRB_BITS'(SUBBLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_DATA  = 3'd2,
    S_WR_WAIT  = 3'd3,
    S_WR_BURST = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_we;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [BLOCK_BITS-1:0]  r_wdata;
  logic [BLOCK_BITS-1:0]  r_rbuf;
  logic [BLOCK_BITS-1:0]  r_rdata;
  logic [BLOCK_BITS-1:0]  w_rmerged;
  logic [STRB_BITS-1:0]   r_wcnt;
  logic [c_BEAT_BITS-1:0] w_wbeat [SUBBLOCKS];
  logic                   w_accept;
  logic                   w_rd_beat;
  logic                   w_rd_last;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_rd_beat = (r_state == S_RD_DATA) && mem_dready;
  assign w_rd_last = w_rd_beat && (mem_rstrb == c_LAST_BEAT);

  // Beat views of the block: write slices by index, and the read buffer
  // with the incoming beat dropped into the slot named by mem_rstrb.
  for (genvar g = 0; g < SUBBLOCKS; g++) begin : g_beat
    assign w_wbeat[g] = r_wdata[g*c_BEAT_BITS +: c_BEAT_BITS];
    assign w_rmerged[g*c_BEAT_BITS +: c_BEAT_BITS] =
      (mem_rstrb == STRB_BITS'(g)) ? mem_rdata : r_rbuf[g*c_BEAT_BITS +: c_BEAT_BITS];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = req_we ? S_WR_WAIT : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        // The request pulse is issued only in the cycle memory takes it.
        if (mem_accR) begin
          mem_en = 1'b1;
          w_next = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (w_rd_last) begin
          w_next = S_RESP;
        end
      end
      S_WR_WAIT: begin
        if (mem_accW) begin
          w_next = S_WR_BURST;
        end
      end
      S_WR_BURST: begin
        mem_we = 1'b1;
        if (r_wcnt == c_LAST_BEAT) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_rdata <= '0;
      r_wcnt  <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wcnt  <= '0;
      end
      if (w_rd_beat) begin
        r_rbuf <= w_rmerged;
      end
      // Published copy changes only when a refill completes.
      if (w_rd_last) begin
        r_rdata <= w_rmerged;
      end
      if (r_state == S_WR_BURST) begin
        r_wcnt <= r_wcnt + STRB_BITS'(1);
      end
    end
  end

  assign mem_addr   = r_addr & c_ALIGN_MASK;
  assign mem_wstrb  = r_wcnt;
  assign mem_wdata  = mem_we ? w_wbeat[r_wcnt] : '0;
  assign resp_we    = resp_valid & r_we;
  assign resp_rdata = r_rdata;

endmodule
`default_nettype wire
